// File: rtl/vec_sum_master.sv
// IOb master that reads LEN signed words from BASE, one request in flight, and sums them.
// Optional write-back of the low DATA_W bits of the sum: define VEC_SUM_WB_EN.
module vec_sum_master #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 16,
    parameter int unsigned ACC_W  = 48
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [ADDR_W-1:0]   base_addr_i,
    input  logic [LEN_W-1:0]    len_i,
    input  logic [ADDR_W-1:0]   result_addr_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [ACC_W-1:0]    sum_o,
    output logic                iob_valid_o,
    output logic [ADDR_W-1:0]   iob_addr_o,
    output logic [DATA_W-1:0]   iob_wdata_o,
    output logic [DATA_W/8-1:0] iob_wstrb_o,
    input  logic [DATA_W-1:0]   iob_rdata_i,
    input  logic                iob_rvalid_i,
    input  logic                iob_ready_i
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned EXT_W  = ACC_W - DATA_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_WB,
        S_DONE
    } state_e;

    state_e              state_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    idx_q;
    logic [ACC_W-1:0]    acc_q;
    logic                busy_q;
    logic                done_q;
    logic                valid_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;

    logic [ACC_W-1:0]    acc_d;
    logic [LEN_W-1:0]    idx_d;

`ifdef VEC_SUM_WB_EN
    logic [ADDR_W-1:0]   result_addr_q;
`else
    logic                unused_result_addr;
    assign unused_result_addr = ^result_addr_i;
`endif

    // Running sum including the word currently on the response bus (sign-extended).
    assign acc_d = acc_q + {{EXT_W{iob_rdata_i[DATA_W-1]}}, iob_rdata_i};
    assign idx_d = idx_q + LEN_W'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            len_q         <= '0;
            idx_q         <= '0;
            acc_q         <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            valid_q       <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
`ifdef VEC_SUM_WB_EN
            result_addr_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        len_q   <= len_i;
                        idx_q   <= '0;
                        acc_q   <= '0;
                        addr_q  <= base_addr_i;
                        wdata_q <= '0;
                        wstrb_q <= '0;
`ifdef VEC_SUM_WB_EN
                        result_addr_q <= result_addr_i;
`endif
                        if (len_i == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_REQ;
                            busy_q  <= 1'b1;
                            valid_q <= 1'b1;
                        end
                    end
                end

                S_REQ: begin
                    if (iob_ready_i) begin
                        valid_q <= 1'b0;
                        state_q <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (iob_rvalid_i) begin
                        acc_q <= acc_d;
                        idx_q <= idx_d;
                        if (idx_d < len_q) begin
                            state_q <= S_REQ;
                            valid_q <= 1'b1;
                            addr_q  <= addr_q + ADDR_W'(STRB_W);
                        end else begin
`ifdef VEC_SUM_WB_EN
                            state_q <= S_WB;
                            valid_q <= 1'b1;
                            addr_q  <= result_addr_q;
                            wdata_q <= acc_d[DATA_W-1:0];
                            wstrb_q <= '1;
`else
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
`endif
                        end
                    end
                end

`ifdef VEC_SUM_WB_EN
                // Write is fire-and-forget: completion on acceptance.
                S_WB: begin
                    if (iob_ready_i) begin
                        valid_q <= 1'b0;
                        wdata_q <= '0;
                        wstrb_q <= '0;
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
`endif

                S_DONE: begin
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign sum_o       = acc_q;
    assign iob_valid_o = valid_q;
    assign iob_addr_o  = addr_q;
    assign iob_wdata_o = wdata_q;
    assign iob_wstrb_o = wstrb_q;

endmodule

// File: tb/tb_vec_sum_master.sv
// Directed bench for vec_sum_master with a one-cycle-latency memory responder.
module tb_vec_sum_master;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LEN_W  = 16;
    localparam int unsigned ACC_W  = 48;
`ifdef VEC_SUM_WB_EN
    localparam int WB_EXTRA = 1;
`else
    localparam int WB_EXTRA = 0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [ADDR_W-1:0]   base;
    logic [LEN_W-1:0]    len;
    logic [ADDR_W-1:0]   raddr;
    logic                busy_o;
    logic                done_o;
    logic [ACC_W-1:0]    sum_o;
    logic                iob_valid_o;
    logic [ADDR_W-1:0]   iob_addr_o;
    logic [DATA_W-1:0]   iob_wdata_o;
    logic [DATA_W/8-1:0] iob_wstrb_o;
    logic [DATA_W-1:0]   rdata = '0;
    logic                rvalid = 1'b0;
    logic                ready;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] rd_log[$];
    logic [31:0] wr_addr_log[$];
    logic [31:0] wr_data_log[$];
    logic [3:0]  wr_strb_log[$];
    int          valid_cycles = 0;

    always #5 clk = ~clk;

    vec_sum_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .ACC_W(ACC_W)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .base_addr_i  (base),
        .len_i        (len),
        .result_addr_i(raddr),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .sum_o        (sum_o),
        .iob_valid_o  (iob_valid_o),
        .iob_addr_o   (iob_addr_o),
        .iob_wdata_o  (iob_wdata_o),
        .iob_wstrb_o  (iob_wstrb_o),
        .iob_rdata_i  (rdata),
        .iob_rvalid_i (rvalid),
        .iob_ready_i  (ready)
    );

    // Memory responder: read data appears the cycle after acceptance.
    always @(posedge clk) begin : resp
        logic        do_rd;
        logic [31:0] a;
        do_rd = iob_valid_o && ready && (iob_wstrb_o == 4'h0);
        a     = iob_addr_o;
        if (iob_valid_o) valid_cycles++;
        if (iob_valid_o && ready && (iob_wstrb_o != 4'h0)) begin
            wr_addr_log.push_back(iob_addr_o);
            wr_data_log.push_back(iob_wdata_o);
            wr_strb_log.push_back(iob_wstrb_o);
        end
        #1;
        rvalid = do_rd;
        rdata  = do_rd ? (mem.exists(a) ? mem[a] : 32'hDEAD_BEEF) : 32'h0;
        if (do_rd) rd_log.push_back(a);
    end

    task automatic pulse_start(input logic [31:0] b, input logic [15:0] l, input logic [31:0] ra);
        base  = b;
        len   = l;
        raddr = ra;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Counts cycles from the start edge until done_o, bounded.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (done_o !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; ready = 1'b1;
        base = '0; len = '0; raddr = '0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({busy_o, done_o, iob_valid_o} !== 3'b000) begin
            n_err++; $display("FAIL reset_ctrl: got %b expected 000", {busy_o, done_o, iob_valid_o});
        end
        n_vec++;
        if (sum_o !== 48'h0) begin
            n_err++; $display("FAIL reset_sum: got %0h expected 0", sum_o);
        end
        n_vec++;
        if ({iob_addr_o, iob_wdata_o, iob_wstrb_o} !== 68'h0) begin
            n_err++; $display("FAIL reset_bus: addr %0h wdata %0h wstrb %0h expected 0", iob_addr_o, iob_wdata_o, iob_wstrb_o);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int cyc;
        int r0;
        logic [31:0] exp_a;
        mem[32'h100] = 32'd1; mem[32'h104] = 32'd2; mem[32'h108] = 32'd3; mem[32'h10C] = 32'd4;
        r0 = rd_log.size();
        pulse_start(32'h100, 16'd4, 32'h200);
        n_vec++;
        if ({busy_o, iob_valid_o} !== 2'b11 || iob_addr_o !== 32'h100 || iob_wstrb_o !== 4'h0) begin
            n_err++; $display("FAIL basic_first_req: busy %b valid %b addr %0h wstrb %0h expected 1 1 100 0", busy_o, iob_valid_o, iob_addr_o, iob_wstrb_o);
        end
        wait_done(cyc);
        n_vec++;
        if (cyc !== 9 + WB_EXTRA) begin
            n_err++; $display("FAIL basic_latency: got %0d expected %0d", cyc, 9 + WB_EXTRA);
        end
        n_vec++;
        if (sum_o !== 48'd10 || busy_o !== 1'b0) begin
            n_err++; $display("FAIL basic_sum: sum %0h busy %b expected a 0", sum_o, busy_o);
        end
        for (int i = 0; i < 4; i++) begin
            exp_a = 32'h100 + 32'(4 * i);
            n_vec++;
            if (rd_log.size() <= r0 + i || rd_log[r0 + i] !== exp_a) begin
                n_err++; $display("FAIL basic_addr%0d: got %0h expected %0h", i, (rd_log.size() > r0 + i) ? rd_log[r0 + i] : 32'hX, exp_a);
            end
        end
        @(posedge clk); #1;
        n_vec++;
        if (done_o !== 1'b0) begin
            n_err++; $display("FAIL basic_done_pulse: got %b expected 0", done_o);
        end
    endtask

    task automatic test_stall_sign();
        int cyc;
        int r0;
        mem[32'h300] = 32'hFFFF_FFFF; mem[32'h304] = 32'hFFFF_FFFE; mem[32'h308] = 32'd5;
        r0 = rd_log.size();
        ready = 1'b0;
        pulse_start(32'h300, 16'd3, 32'h200);
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (iob_valid_o !== 1'b1 || iob_addr_o !== 32'h300 || iob_wstrb_o !== 4'h0) begin
                n_err++; $display("FAIL stall_hold%0d: valid %b addr %0h wstrb %0h expected 1 300 0", i, iob_valid_o, iob_addr_o, iob_wstrb_o);
            end
            @(posedge clk); #1;
        end
        ready = 1'b1;
        wait_done(cyc);
        n_vec++;
        if (sum_o !== 48'd2) begin
            n_err++; $display("FAIL stall_sign_sum: got %0h expected 2", sum_o);
        end
        n_vec++;
        if (rd_log.size() != r0 + 3 || rd_log[r0 + 2] !== 32'h308) begin
            n_err++; $display("FAIL stall_reads: count %0d expected 3", rd_log.size() - r0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_len_zero();
        int v0;
        v0 = valid_cycles;
        pulse_start(32'h100, 16'd0, 32'h200);
        n_vec++;
        if (done_o !== 1'b1 || busy_o !== 1'b0 || sum_o !== 48'h0) begin
            n_err++; $display("FAIL len0_done: done %b busy %b sum %0h expected 1 0 0", done_o, busy_o, sum_o);
        end
        @(posedge clk); #1;
        n_vec++;
        if (done_o !== 1'b0 || valid_cycles != v0) begin
            n_err++; $display("FAIL len0_quiet: done %b valid cycles %0d expected 0 0", done_o, valid_cycles - v0);
        end
    endtask

    task automatic test_busy_start();
        int cyc;
        int r0;
        r0 = rd_log.size();
        pulse_start(32'h100, 16'd4, 32'h200);
        @(posedge clk); #1;
        @(posedge clk); #1;
        pulse_start(32'h300, 16'd3, 32'h400);
        wait_done(cyc);
        n_vec++;
        if (sum_o !== 48'd10) begin
            n_err++; $display("FAIL busy_start_sum: got %0h expected a", sum_o);
        end
        n_vec++;
        if (rd_log.size() != r0 + 4 || rd_log[r0 + 3] !== 32'h10C) begin
            n_err++; $display("FAIL busy_start_reads: count %0d expected 4", rd_log.size() - r0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_done_start();
        int cyc;
        pulse_start(32'h104, 16'd1, 32'h200);
        wait_done(cyc);
        n_vec++;
        if (cyc !== 3 + WB_EXTRA || sum_o !== 48'd2) begin
            n_err++; $display("FAIL done_start_run: cyc %0d sum %0h expected %0d 2", cyc, sum_o, 3 + WB_EXTRA);
        end
        base = 32'h100; len = 16'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (busy_o !== 1'b0 || iob_valid_o !== 1'b0) begin
            n_err++; $display("FAIL done_start_ignored: busy %b valid %b expected 0 0", busy_o, iob_valid_o);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        pulse_start(32'h100, 16'd4, 32'h200);
        repeat (3) begin @(posedge clk); #1; end
        n_vec++;
        if (iob_valid_o !== 1'b0 || busy_o !== 1'b1 || sum_o !== 48'd1) begin
            n_err++; $display("FAIL mid_pre: valid %b busy %b sum %0h expected 0 1 1", iob_valid_o, busy_o, sum_o);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if ({iob_valid_o, busy_o, done_o} !== 3'b000 || sum_o !== 48'h0) begin
            n_err++; $display("FAIL mid_reset: vbd %b sum %0h expected 000 0", {iob_valid_o, busy_o, done_o}, sum_o);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        pulse_start(32'h100, 16'd2, 32'h200);
        wait_done(cyc);
        n_vec++;
        if (cyc !== 5 + WB_EXTRA || sum_o !== 48'd3) begin
            n_err++; $display("FAIL mid_restart: cyc %0d sum %0h expected %0d 3", cyc, sum_o, 5 + WB_EXTRA);
        end
        @(posedge clk); #1;
    endtask

`ifdef VEC_SUM_WB_EN
    task automatic test_wb();
        int cyc;
        int w0;
        mem[32'h100] = 32'd7; mem[32'h104] = 32'd8;
        w0 = wr_addr_log.size();
        pulse_start(32'h100, 16'd2, 32'h200);
        wait_done(cyc);
        n_vec++;
        if (cyc !== 6 || sum_o !== 48'd15) begin
            n_err++; $display("FAIL wb_run: cyc %0d sum %0h expected 6 f", cyc, sum_o);
        end
        n_vec++;
        if (wr_addr_log.size() != w0 + 1 || wr_addr_log[w0] !== 32'h200 || wr_data_log[w0] !== 32'd15 || wr_strb_log[w0] !== 4'hF) begin
            n_err++; $display("FAIL wb_write: writes %0d expected 1 at 200 data f strb f", wr_addr_log.size() - w0);
        end
        @(posedge clk); #1;
    endtask
`else
    task automatic test_no_write();
        n_vec++;
        if (wr_addr_log.size() != 0) begin
            n_err++; $display("FAIL no_write: got %0d writes expected 0", wr_addr_log.size());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stall_sign();
        test_len_zero();
        test_busy_start();
        test_done_start();
        test_reset_mid();
`ifdef VEC_SUM_WB_EN
        test_wb();
`else
        test_no_write();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
